reg_file_mp: RTL

Parametrised multi-port integer register file, successor to the fixed 2-read/1-write RV32I register file in the datapath. Adds a configurable data width, depth, read-port count and write-port count, write-to-read bypass, an asynchronous clearing reset, and a per-register busy scoreboard. Together these support a dual-issue core with writeback forwarding.

---
 rtl/reg_file_mp_pkg.sv | 12 +
 rtl/reg_file_mp_if.sv | 27 ++
 rtl/reg_file_mp_scoreboard.sv | 38 +++
 rtl/reg_file_mp.sv | 83 ++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared constants and flattened-vector slice helpers for the multi-port register file.
// Pure declarations: no logic, no latency, no flow control.
`ifndef RF_PKG_MACROS
`define RF_PKG_MACROS
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package rf_pkg;
   localparam int unsigned XLEN_DEF   = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned ZERO_REG   = 0;
endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/issue bundle between the issue/writeback stages and the register file.
// Reads are combinational and there is no backpressure: every write and issue is accepted.
interface reg_file_mp_if #(
   parameter int XLEN   = rf_pkg::XLEN_DEF,
   parameter int ADDR_W = rf_pkg::ADDR_W_DEF,
   parameter int N_RD   = 3,
   parameter int N_WR   = 2
);
   logic [N_RD*ADDR_W-1:0] rs_addr;
   logic [N_RD*XLEN-1:0]   rs_data;
   logic [N_RD-1:0]        rs_busy;
   logic [N_WR-1:0]        cu_rdwrite;
   logic [N_WR*ADDR_W-1:0] rd_addr;
   logic [N_WR*XLEN-1:0]   rd_in;
   logic                   cu_issue;
   logic [ADDR_W-1:0]      issue_addr;

   modport master (
      output rs_addr, cu_rdwrite, rd_addr, rd_in, cu_issue, issue_addr,
      input  rs_data, rs_busy
   );

   modport slave (
      input  rs_addr, cu_rdwrite, rd_addr, rd_in, cu_issue, issue_addr,
      output rs_data, rs_busy
   );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set wins on a same-cycle clash.
// Busy updates one edge after issue/writeback; no backpressure.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 issue_vld,
   input  logic [ADDR_W-1:0]    issue_addr,
   input  logic [2**ADDR_W-1:0] clr_vec,
   output logic [2**ADDR_W-1:0] busy_q
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

   logic [DEPTH-1:0] set_vec;
   logic [DEPTH-1:0] busy_d;

   always_comb begin
      set_vec = '0;
      if (issue_vld && (issue_addr != ZERO_A)) begin
         set_vec[issue_addr] = 1'b1;
      end
      // The newer producer stays outstanding, so set overrides clear.
      busy_d    = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end
endmodule

// File: rtl/reg_file_mp.sv
// Parametrised N_RD-read / N_WR-write register file with x0 hardwired, optional bypass and busy scoreboard.
// Reads are zero-latency, writes land on the next edge; no backpressure.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int N_RD   = 3,
   parameter int N_WR   = 2,
   parameter int BYPASS = 1
) (
   input logic          clock,
   input logic          reset_n,
   reg_file_mp_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

   logic [XLEN-1:0]  regs_q [DEPTH-1:1];
   logic [XLEN-1:0]  regs_d [DEPTH];
   logic [DEPTH-1:0] regs_we;
   logic [DEPTH-1:0] busy_q;
   logic             issue_vld;

   assign issue_vld = reset_n & bus.cu_issue;

   // Ascending port order lets the highest-indexed enabled port win both storage and bypass.
   always_comb begin
      for (int a = 0; a < DEPTH; a++) begin
         regs_we[a] = 1'b0;
         regs_d[a]  = '0;
      end
      for (int w = 0; w < N_WR; w++) begin
         if (reset_n && bus.cu_rdwrite[w] && (`RF_SLICE(bus.rd_addr, w, ADDR_W) != ZERO_A)) begin
            regs_we[`RF_SLICE(bus.rd_addr, w, ADDR_W)] = 1'b1;
            regs_d[`RF_SLICE(bus.rd_addr, w, ADDR_W)]  = `RF_SLICE(bus.rd_in, w, XLEN);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int a = 1; a < DEPTH; a++) begin
            regs_q[a] <= '0;
         end
      end else begin
         for (int a = 1; a < DEPTH; a++) begin
            if (regs_we[a]) begin
               regs_q[a] <= regs_d[a];
            end
         end
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clock      (clock),
      .reset_n    (reset_n),
      .issue_vld  (issue_vld),
      .issue_addr (bus.issue_addr),
      .clr_vec    (regs_we),
      .busy_q     (busy_q)
   );

   for (genvar r = 0; r < N_RD; r++) begin : g_rd
      logic [ADDR_W-1:0] rd_a;
      logic [XLEN-1:0]   stored;

      assign rd_a   = `RF_SLICE(bus.rs_addr, r, ADDR_W);
      assign stored = (rd_a == ZERO_A) ? '0 : regs_q[rd_a];

      if (BYPASS != 0) begin : g_byp
         logic issue_same;
         assign issue_same = issue_vld && (bus.issue_addr == rd_a);
         assign `RF_SLICE(bus.rs_data, r, XLEN) = regs_we[rd_a] ? regs_d[rd_a] : stored;
         assign bus.rs_busy[r] = busy_q[rd_a] & ~(regs_we[rd_a] & ~issue_same);
      end else begin : g_nobyp
         assign `RF_SLICE(bus.rs_data, r, XLEN) = stored;
         assign bus.rs_busy[r] = busy_q[rd_a];
      end
   end
endmodule
